// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave bridging a 128-bit single-port SRAM into a byte-addressed window.
// Each accepted transfer is one SRAM access after WAIT_CYCLES stall cycles; illegal ones get a two-cycle ERROR.
module ahb_sram_slave #(
    parameter logic [39:0] BASE_ADDR   = 40'h0,
    parameter int          MEM_AW      = 14,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst_b,
    input  logic              hsel,
    input  logic [39:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic [127:0]      hwdata,
    output logic [127:0]      hrdata,
    output logic              hready,
    output logic [1:0]        hresp,
    output logic              mem_cen,
    output logic              mem_gwen,
    output logic [15:0]       mem_wen,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic [127:0]      mem_rdata
);

    localparam int OFF_W = MEM_AW + 4;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RESP,
        ERR1,
        ERR2
    } state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    state_t             state;
    logic [3:0]         wait_cnt;
    logic [OFF_W-1:0]   offset_q;
    logic               write_q;
    logic [2:0]         size_q;
    logic               hready_q;
    logic [1:0]         hresp_q;

    logic [39:0]        offset;
    logic [3:0]         align_mask;
    logic               xfer_err;
    logic               addr_phase;
    logic               sram_access;
    logic [15:0]        lane_span;
    logic [15:0]        lane_mask;
    logic               unused_inputs;

    // Window offset wraps modulo 2^40, so addresses below BASE_ADDR land far out of range.
    assign offset = haddr - BASE_ADDR;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        align_mask = 4'h0;
        case (hsize)
            3'd1:    align_mask = 4'h1;
            3'd2:    align_mask = 4'h3;
            3'd3:    align_mask = 4'h7;
            3'd4:    align_mask = 4'hF;
            default: align_mask = 4'h0;
        endcase
    end

    assign xfer_err = (hsize > 3'd4)
                   || ((haddr[3:0] & align_mask) != 4'h0)
                   || (offset[39:OFF_W] != '0);

    assign addr_phase = hsel && htrans[1]
                     && (state == IDLE || state == RESP || state == ERR2);

    // Gated by reset so an ACCESS that is aborted never reaches the SRAM.
    assign sram_access = pad_cpu_rst_b && (state == ACCESS) && (wait_cnt == 4'd0);

    always_comb begin
        lane_span = 16'hFFFF;
        case (size_q)
            3'd0:    lane_span = 16'h0001;
            3'd1:    lane_span = 16'h0003;
            3'd2:    lane_span = 16'h000F;
            3'd3:    lane_span = 16'h00FF;
            default: lane_span = 16'hFFFF;
        endcase
        lane_mask = lane_span << offset_q[3:0];
    end

    // Write data is only valid in the data phase, so the SRAM strobe is decoded, not registered.
    always_comb begin
        mem_cen   = 1'b1;
        mem_gwen  = 1'b1;
        mem_wen   = 16'hFFFF;
        mem_addr  = '0;
        mem_wdata = '0;
        if (sram_access) begin
            mem_cen  = 1'b0;
            mem_gwen = ~write_q;
            mem_addr = offset_q[OFF_W-1:4];
            if (write_q) begin
                mem_wdata = hwdata;
                mem_wen   = ~lane_mask;
            end
        end
    end

    assign hrdata = (pad_cpu_rst_b && state == RESP && !write_q) ? mem_rdata : '0;
    assign hready = hready_q || !pad_cpu_rst_b;
    assign hresp  = pad_cpu_rst_b ? hresp_q : RESP_OKAY;

    assign unused_inputs = ^{hburst, hprot, htrans[0]};

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge pll_core_cpuclk) begin
        if (!pad_cpu_rst_b) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            offset_q <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            hready_q <= 1'b1;
            hresp_q  <= RESP_OKAY;
        end else begin
            case (state)
                IDLE, RESP, ERR2: begin
                    if (addr_phase) begin
                        offset_q <= offset[OFF_W-1:0];
                        write_q  <= hwrite;
                        size_q   <= hsize;
                        hready_q <= 1'b0;
                        if (xfer_err) begin
                            state   <= ERR1;
                            hresp_q <= RESP_ERROR;
                        end else begin
                            state    <= ACCESS;
                            wait_cnt <= 4'(WAIT_CYCLES);
                            hresp_q  <= RESP_OKAY;
                        end
                    end else begin
                        state    <= IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= RESP_OKAY;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        state    <= RESP;
                        hready_q <= 1'b1;
                        hresp_q  <= RESP_OKAY;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ERR1: begin
                    state    <= ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= RESP_ERROR;
                end
                default: begin
                    state    <= IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= RESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: three instances (0/3/5 wait cycles) each backed by a
// behavioural SRAM, scored against a byte-array model of the window.
module tb_ahb_sram_slave;

    localparam int          MEM_AW = 10;
    localparam int          NDUT   = 3;
    localparam int          WIN    = 2 ** (MEM_AW + 4);
    localparam logic [39:0] BASE1  = 40'h12_3400_0000;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0] hsel;
    logic [39:0]     haddr;
    logic [1:0]      htrans;
    logic            hwrite;
    logic [2:0]      hsize;
    logic [2:0]      hburst;
    logic [3:0]      hprot;
    logic [127:0]    hwdata;

    logic [127:0]      hrdata    [NDUT];
    logic              hready    [NDUT];
    logic [1:0]        hresp     [NDUT];
    logic              mem_cen   [NDUT];
    logic              mem_gwen  [NDUT];
    logic [15:0]       mem_wen   [NDUT];
    logic [MEM_AW-1:0] mem_addr  [NDUT];
    logic [127:0]      mem_wdata [NDUT];

    int pass_cnt  = 0;
    int check_cnt = 0;

    bit [7:0] ref_mem [NDUT][WIN];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int          WAIT_G = (g == 0) ? 0 : (g == 1) ? 3 : 5;
        localparam logic [39:0] BASE_G = (g == 1) ? BASE1 : 40'h0;

        bit [127:0] sram [2 ** MEM_AW];
        bit [127:0] rdata_q;

        ahb_sram_slave #(
            .BASE_ADDR  (BASE_G),
            .MEM_AW     (MEM_AW),
            .WAIT_CYCLES(WAIT_G)
        ) dut (
            .pll_core_cpuclk(clk),
            .pad_cpu_rst_b  (rst_b),
            .hsel           (hsel[g]),
            .haddr          (haddr),
            .htrans         (htrans),
            .hwrite         (hwrite),
            .hsize          (hsize),
            .hburst         (hburst),
            .hprot          (hprot),
            .hwdata         (hwdata),
            .hrdata         (hrdata[g]),
            .hready         (hready[g]),
            .hresp          (hresp[g]),
            .mem_cen        (mem_cen[g]),
            .mem_gwen       (mem_gwen[g]),
            .mem_wen        (mem_wen[g]),
            .mem_addr       (mem_addr[g]),
            .mem_wdata      (mem_wdata[g]),
            .mem_rdata      (rdata_q)
        );

        always @(posedge clk) begin
            if (!mem_cen[g]) begin
                if (!mem_gwen[g]) begin
                    for (int b = 0; b < 16; b++)
                        if (!mem_wen[g][b]) sram[mem_addr[g]][b*8 +: 8] <= mem_wdata[g][b*8 +: 8];
                end else begin
                    rdata_q <= sram[mem_addr[g]];
                end
            end
        end
    end

    typedef struct {
        int                stall;
        int                cen_cnt;
        int                cen_at;
        logic [1:0]        stall_resp;
        logic [1:0]        resp;
        logic [127:0]      rdata;
        logic [MEM_AW-1:0] acc_addr;
        logic [15:0]       acc_wen;
        logic              acc_gwen;
        logic [127:0]      acc_wdata;
    } obs_t;

    function automatic logic [39:0] base_of(input int d);
        return (d == 1) ? BASE1 : 40'h0;
    endfunction

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 5;
    endfunction

    function automatic logic exp_err(input int d, input logic [39:0] a, input logic [2:0] sz);
        logic [39:0] off;
        off = a - base_of(d);
        if (sz > 3'd4) return 1'b1;
        if ((a % (40'd1 << sz)) != 40'd0) return 1'b1;
        return off >= 40'(WIN);
    endfunction

    // Reference: what the slave should show for one transfer, updating the byte image on writes.
    task automatic model(input int d, input logic [39:0] a, input logic w, input logic [2:0] sz,
                         input logic [127:0] wd, output obs_t e);
        logic [39:0] off;
        int          lo, nb, wbase;
        e = '{default: 0};
        e.acc_wen = 16'hFFFF;
        if (exp_err(d, a, sz)) begin
            e.stall      = 1;
            e.stall_resp = 2'b01;
            e.resp       = 2'b01;
            return;
        end
        off   = a - base_of(d);
        lo    = int'(off[3:0]);
        nb    = 1 << sz;
        wbase = int'(off[MEM_AW+3:0]) - lo;
        e.stall    = wait_of(d) + 1;
        e.cen_cnt  = 1;
        e.cen_at   = wait_of(d);
        e.acc_addr = off[MEM_AW+3:4];
        e.acc_gwen = ~w;
        for (int b = 0; b < 16; b++) begin
            if (w && b >= lo && b < lo + nb) begin
                e.acc_wen[b] = 1'b0;
                ref_mem[d][wbase + b] = wd[b*8 +: 8];
            end
            if (!w) e.rdata[b*8 +: 8] = ref_mem[d][wbase + b];
        end
        if (w) e.acc_wdata = wd;
    endtask

    // Drives one isolated transfer and records what the data phase looked like.
    task automatic xfer(input int d, input logic [39:0] a, input logic w, input logic [2:0] sz,
                        input logic [127:0] wd, output obs_t o);
        bit done;
        o = '{default: 0};
        o.stall = 99;
        @(posedge clk); #1;
        hsel   = 3'b001 << d;
        haddr  = a;
        htrans = 2'b10;
        hwrite = w;
        hsize  = sz;
        hburst = 3'($urandom);
        hprot  = 4'($urandom);
        @(posedge clk); #1;
        hsel   = '0;
        htrans = 2'($urandom_range(0, 1));
        haddr  = {8'h0, $urandom};
        hwdata = wd;
        o.stall = 0;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (!mem_cen[d]) begin
                o.cen_cnt++;
                o.cen_at    = o.stall;
                o.acc_addr  = mem_addr[d];
                o.acc_wen   = mem_wen[d];
                o.acc_gwen  = mem_gwen[d];
                o.acc_wdata = mem_wdata[d];
            end
            if (hready[d]) begin
                o.resp  = hresp[d];
                o.rdata = hrdata[d];
                done    = 1'b1;
            end else begin
                o.stall_resp |= hresp[d];
                o.stall++;
            end
        end
    endtask

    task automatic test_reset();
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) begin
                repeat (2) @(posedge clk);
            end else begin
                @(posedge clk); #1;
                rst_b = 1'b1;
            end
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                check_cnt++; if (hready[d] !== 1'b1) $display("FAIL reset%0d_hready dut%0d got %b want 1", phase, d, hready[d]); else pass_cnt++;
                check_cnt++; if (hresp[d] !== 2'b00) $display("FAIL reset%0d_hresp dut%0d got %b want 00", phase, d, hresp[d]); else pass_cnt++;
                check_cnt++; if (hrdata[d] !== '0) $display("FAIL reset%0d_hrdata dut%0d got %h want 0", phase, d, hrdata[d]); else pass_cnt++;
                check_cnt++; if ({mem_cen[d], mem_gwen[d], mem_wen[d]} !== {2'b11, 16'hFFFF})
                    $display("FAIL reset%0d_mem_ctl dut%0d got %b_%b_%h want 1_1_ffff", phase, d, mem_cen[d], mem_gwen[d], mem_wen[d]); else pass_cnt++;
                check_cnt++; if (mem_addr[d] !== '0) $display("FAIL reset%0d_mem_addr dut%0d got %h want 0", phase, d, mem_addr[d]); else pass_cnt++;
                check_cnt++; if (mem_wdata[d] !== '0) $display("FAIL reset%0d_mem_wdata dut%0d got %h want 0", phase, d, mem_wdata[d]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_idle_busy();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            hsel   = '1;
            htrans = 2'(c % 2);
            haddr  = {8'h0, $urandom};
            hwrite = 1'($urandom);
            hsize  = 3'($urandom_range(0, 4));
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                check_cnt++; if ({hready[d], hresp[d], mem_cen[d]} !== 4'b1001)
                    $display("FAIL idle_busy_c%0d dut%0d got hready=%b hresp=%b cen=%b want 1 00 1", c, d, hready[d], hresp[d], mem_cen[d]); else pass_cnt++;
            end
        end
        @(posedge clk); #1;
        hsel   = '0;
        htrans = 2'b00;
    endtask

    task automatic test_write_full();
        obs_t o, e;
        model(0, 40'h40, 1'b1, 3'd4, {16{8'hA5}}, e);
        xfer(0, 40'h40, 1'b1, 3'd4, {16{8'hA5}}, o);
        check_cnt++; if (o.stall !== 1) $display("FAIL wr_full_stall got %0d want 1", o.stall); else pass_cnt++;
        check_cnt++; if (o.cen_cnt !== 1) $display("FAIL wr_full_cen_cnt got %0d want 1", o.cen_cnt); else pass_cnt++;
        check_cnt++; if (o.acc_addr !== 10'd4) $display("FAIL wr_full_mem_addr got %h want 4", o.acc_addr); else pass_cnt++;
        check_cnt++; if (o.acc_wen !== 16'h0000) $display("FAIL wr_full_mem_wen got %h want 0000", o.acc_wen); else pass_cnt++;
        check_cnt++; if (o.acc_wdata !== {16{8'hA5}}) $display("FAIL wr_full_mem_wdata got %h want a5..a5", o.acc_wdata); else pass_cnt++;
        check_cnt++; if (o.resp !== 2'b00) $display("FAIL wr_full_resp got %b want 00", o.resp); else pass_cnt++;
        check_cnt++; if (o.rdata !== e.rdata) $display("FAIL wr_full_hrdata got %h want %h", o.rdata, e.rdata); else pass_cnt++;
    endtask

    task automatic test_byte_write_read();
        obs_t         o, e;
        logic [127:0] wd, want;
        wd = {$urandom, $urandom, $urandom, $urandom};
        model(0, 40'h43, 1'b1, 3'd0, wd, e);
        xfer(0, 40'h43, 1'b1, 3'd0, wd, o);
        check_cnt++; if (o.acc_wen !== 16'hFFF7) $display("FAIL byte_wr_mem_wen got %h want fff7", o.acc_wen); else pass_cnt++;
        check_cnt++; if (o.resp !== 2'b00) $display("FAIL byte_wr_resp got %b want 00", o.resp); else pass_cnt++;
        want = {16{8'hA5}};
        want[31:24] = wd[31:24];
        model(0, 40'h40, 1'b0, 3'd4, '0, e);
        xfer(0, 40'h40, 1'b0, 3'd4, '0, o);
        check_cnt++; if (o.acc_wen !== 16'hFFFF || o.acc_gwen !== 1'b1) $display("FAIL byte_rd_mem_ctl got wen=%h gwen=%b want ffff 1", o.acc_wen, o.acc_gwen); else pass_cnt++;
        check_cnt++; if (o.rdata !== want) $display("FAIL byte_rd_hrdata got %h want %h", o.rdata, want); else pass_cnt++;
    endtask

    task automatic test_wait_states();
        obs_t o, e;
        model(1, BASE1 + 40'h100, 1'b0, 3'd4, '0, e);
        xfer(1, BASE1 + 40'h100, 1'b0, 3'd4, '0, o);
        check_cnt++; if (o.stall !== 4) $display("FAIL wait3_stall got %0d want 4", o.stall); else pass_cnt++;
        check_cnt++; if (o.cen_cnt !== 1) $display("FAIL wait3_cen_cnt got %0d want 1", o.cen_cnt); else pass_cnt++;
        check_cnt++; if (o.cen_at !== 3) $display("FAIL wait3_cen_cycle got %0d want 3", o.cen_at); else pass_cnt++;
        check_cnt++; if (o.acc_addr !== 10'h10) $display("FAIL wait3_mem_addr got %h want 010", o.acc_addr); else pass_cnt++;
        check_cnt++; if (o.resp !== 2'b00 || o.stall_resp !== 2'b00) $display("FAIL wait3_resp got %b/%b want 00/00", o.stall_resp, o.resp); else pass_cnt++;
        check_cnt++; if (o.rdata !== e.rdata) $display("FAIL wait3_hrdata got %h want %h", o.rdata, e.rdata); else pass_cnt++;
    endtask

    task automatic test_errors();
        obs_t        o, e;
        int          dl [4] = '{0, 0, 1, 1};
        logic [39:0] al [4] = '{40'h42, 40'(WIN), BASE1 - 40'h10, BASE1 + 40'h20};
        logic [2:0]  sl [4] = '{3'd2, 3'd4, 3'd4, 3'd5};
        for (int i = 0; i < 4; i++) begin
            model(dl[i], al[i], 1'b1, sl[i], '1, e);
            xfer(dl[i], al[i], 1'b1, sl[i], '1, o);
            check_cnt++; if (o.stall !== 1) $display("FAIL err%0d_stall got %0d want 1", i, o.stall); else pass_cnt++;
            check_cnt++; if (o.stall_resp !== 2'b01) $display("FAIL err%0d_err1_hresp got %b want 01", i, o.stall_resp); else pass_cnt++;
            check_cnt++; if (o.resp !== 2'b01) $display("FAIL err%0d_err2_hresp got %b want 01", i, o.resp); else pass_cnt++;
            check_cnt++; if (o.cen_cnt !== 0) $display("FAIL err%0d_cen_cnt got %0d want 0", i, o.cen_cnt); else pass_cnt++;
            check_cnt++; if (o.rdata !== e.rdata) $display("FAIL err%0d_hrdata got %h want %h", i, o.rdata, e.rdata); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t         e;
        logic [127:0] wd;
        wd = {$urandom, $urandom, $urandom, $urandom};
        model(0, 40'h200, 1'b1, 3'd4, wd, e);
        model(0, 40'h200, 1'b0, 3'd4, '0, e);
        @(posedge clk); #1;
        hsel = 3'b001; haddr = 40'h200; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd4;
        @(posedge clk); #1;
        hwrite = 1'b0;
        hwdata = wd;
        @(negedge clk);
        check_cnt++; if ({hready[0], mem_cen[0], mem_gwen[0]} !== 3'b000)
            $display("FAIL b2b_wr_access got hready=%b cen=%b gwen=%b want 0 0 0", hready[0], mem_cen[0], mem_gwen[0]); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if ({hready[0], hresp[0]} !== 3'b100) $display("FAIL b2b_wr_resp got hready=%b hresp=%b want 1 00", hready[0], hresp[0]); else pass_cnt++;
        @(posedge clk); #1;
        hsel   = '0;
        htrans = 2'b00;
        @(negedge clk);
        check_cnt++; if ({hready[0], mem_cen[0], mem_gwen[0]} !== 3'b001)
            $display("FAIL b2b_rd_access got hready=%b cen=%b gwen=%b want 0 0 1", hready[0], mem_cen[0], mem_gwen[0]); else pass_cnt++;
        check_cnt++; if (mem_addr[0] !== 10'h20) $display("FAIL b2b_rd_mem_addr got %h want 020", mem_addr[0]); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (hready[0] !== 1'b1 || hrdata[0] !== wd) $display("FAIL b2b_rd_data got hready=%b hrdata=%h want 1 %h", hready[0], hrdata[0], wd); else pass_cnt++;
        check_cnt++; if (e.rdata !== wd) $display("FAIL b2b_model_data got %h want %h", e.rdata, wd); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        obs_t         o, e;
        logic [127:0] v1, v2;
        v1 = {$urandom, $urandom, $urandom, $urandom};
        v2 = ~v1;
        model(2, 40'h300, 1'b1, 3'd4, v1, e);
        xfer(2, 40'h300, 1'b1, 3'd4, v1, o);
        check_cnt++; if (o.stall !== 6) $display("FAIL abort_prewrite_stall got %0d want 6", o.stall); else pass_cnt++;
        @(posedge clk); #1;
        hsel = 3'b100; haddr = 40'h300; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd4;
        @(posedge clk); #1;
        hsel = '0; htrans = 2'b00; hwdata = v2;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_cnt++; if ({hready[2], mem_cen[2]} !== 2'b01) $display("FAIL abort_access%0d got hready=%b cen=%b want 0 1", c, hready[2], mem_cen[2]); else pass_cnt++;
        end
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(negedge clk);
        check_cnt++; if ({hready[2], mem_cen[2]} !== 2'b11) $display("FAIL abort_rst_cycle got hready=%b cen=%b want 1 1", hready[2], mem_cen[2]); else pass_cnt++;
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(negedge clk);
        check_cnt++; if ({hready[2], hresp[2], mem_cen[2]} !== 4'b1001 || hrdata[2] !== '0)
            $display("FAIL abort_idle got hready=%b hresp=%b cen=%b hrdata=%h want 1 00 1 0", hready[2], hresp[2], mem_cen[2], hrdata[2]); else pass_cnt++;
        model(2, 40'h300, 1'b0, 3'd4, '0, e);
        xfer(2, 40'h300, 1'b0, 3'd4, '0, o);
        check_cnt++; if (o.rdata !== v1) $display("FAIL abort_readback got %h want %h", o.rdata, v1); else pass_cnt++;
    endtask

    function automatic logic [39:0] rand_addr(input int d, input logic [2:0] sz);
        int          kind;
        int          nb;
        logic [39:0] off;
        kind = $urandom_range(0, 15);
        nb   = (sz <= 3'd4) ? (1 << sz) : 1;
        off  = 40'($urandom_range(0, WIN - 1));
        off  = off & ~(40'(nb) - 40'd1);
        if (kind == 0)      off = 40'(WIN) + 40'($urandom_range(0, 255)) * 40'd16;
        else if (kind == 1) off[3:0] = 4'($urandom);
        else if (kind == 2) off = 40'hFF_FFFF_FFF0;
        return base_of(d) + off;
    endfunction

    task automatic test_random(input int d, input int n);
        obs_t         o, e;
        logic [39:0]  a;
        logic [2:0]   sz;
        logic         w;
        logic [127:0] wd;
        for (int i = 0; i < n; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            w  = 1'($urandom);
            a  = rand_addr(d, sz);
            wd = {$urandom, $urandom, $urandom, $urandom};
            model(d, a, w, sz, wd, e);
            xfer(d, a, w, sz, wd, o);
            check_cnt++; if (o.stall !== e.stall) $display("FAIL rnd_d%0d_%0d_stall a=%h sz=%0d got %0d want %0d", d, i, a, sz, o.stall, e.stall); else pass_cnt++;
            check_cnt++; if (o.stall_resp !== e.stall_resp || o.resp !== e.resp)
                $display("FAIL rnd_d%0d_%0d_hresp a=%h got %b/%b want %b/%b", d, i, a, o.stall_resp, o.resp, e.stall_resp, e.resp); else pass_cnt++;
            check_cnt++; if (o.cen_cnt !== e.cen_cnt) $display("FAIL rnd_d%0d_%0d_cen_cnt a=%h got %0d want %0d", d, i, a, o.cen_cnt, e.cen_cnt); else pass_cnt++;
            check_cnt++; if (o.rdata !== e.rdata) $display("FAIL rnd_d%0d_%0d_hrdata a=%h got %h want %h", d, i, a, o.rdata, e.rdata); else pass_cnt++;
            if (e.cen_cnt == 1) begin
                check_cnt++; if (o.cen_at !== e.cen_at) $display("FAIL rnd_d%0d_%0d_cen_cycle got %0d want %0d", d, i, o.cen_at, e.cen_at); else pass_cnt++;
                check_cnt++; if (o.acc_addr !== e.acc_addr || o.acc_gwen !== e.acc_gwen)
                    $display("FAIL rnd_d%0d_%0d_mem_addr got %h/%b want %h/%b", d, i, o.acc_addr, o.acc_gwen, e.acc_addr, e.acc_gwen); else pass_cnt++;
                check_cnt++; if (o.acc_wen !== e.acc_wen) $display("FAIL rnd_d%0d_%0d_mem_wen a=%h sz=%0d got %h want %h", d, i, a, sz, o.acc_wen, e.acc_wen); else pass_cnt++;
                if (w) begin
                    check_cnt++; if (o.acc_wdata !== e.acc_wdata) $display("FAIL rnd_d%0d_%0d_mem_wdata got %h want %h", d, i, o.acc_wdata, e.acc_wdata); else pass_cnt++;
                end
            end
        end
    endtask

    initial begin
        hsel   = '0;
        haddr  = '0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'd0;
        hburst = 3'd0;
        hprot  = 4'd0;
        hwdata = '0;
        test_reset();
        test_idle_busy();
        test_write_full();
        test_byte_write_read();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        test_random(0, 80);
        test_random(1, 60);
        test_random(2, 30);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 40'h0, byte address of SRAM window start.
REQ-002 SHALL have parameter MEM_AW, default 14, SRAM word-index width (128-bit words).
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, legal 0..15, extra data-phase stall cycles.
REQ-004 SHALL have ports, one per line, as follows:
 pll_core_cpuclk  in  1  sole clock, rising edge.
 pad_cpu_rst_b  in  1  reset; one clock; reset is synchronous and active-low.
 hsel  in  1  slave select from fabric.
 haddr  in  40  byte address.
 htrans  in  2  transfer type; bit1=1 NONSEQ/SEQ.
 hwrite  in  1  1=write.
 hsize  in  3  0..4 = 1/2/4/8/16 bytes.
 hburst  in  3  accepted, ignored.
 hprot  in  4  accepted, ignored.
 hwdata  in  128  write data, data phase.
 hrdata  out  128  read data.
 hready  out  1  transfer done.
 hresp  out  2  00 OKAY, 01 ERROR.
 mem_cen  out  1  SRAM chip enable, active-low.
 mem_gwen  out  1  SRAM global write enable, active-low.
 mem_wen  out  16  SRAM byte write enables, active-low, bit n = byte n.
 mem_addr  out  MEM_AW  SRAM word index.
 mem_wdata  out  128  SRAM write data.
 mem_rdata  in  128  SRAM read data, valid one cycle after read enable.

Function
REQ-005 SHALL implement FSM states IDLE, ACCESS, RESP, ERR1, ERR2.
REQ-006 SHALL accept an address phase when hsel=1, htrans[1]=1, and state in {IDLE, RESP, ERR2}; latch haddr, hwrite, hsize.
REQ-007 SHALL compute offset = haddr - BASE_ADDR (40-bit, wrap-around); error if offset >= 2^(MEM_AW+4), hsize>4, or haddr not aligned to 2^hsize bytes.
REQ-008 SHALL go to ERR1 on accepted erroneous transfer, else to ACCESS with wait counter loaded to WAIT_CYCLES.
REQ-009 SHALL in ACCESS drive hready=0, hresp=00; decrement counter each cycle; on counter=0 issue one SRAM access and go to RESP.
REQ-010 SHALL for the SRAM access drive mem_cen=0, mem_addr=offset[MEM_AW+3:4], mem_gwen=~write; for writes mem_wdata=hwdata and mem_wen bits [offset[3:0] +: 2^hsize] = 0, others 1; for reads mem_wen=16'hFFFF.
REQ-011 SHALL in RESP drive hready=1, hresp=00, hrdata=mem_rdata for reads, 0 for writes.
REQ-012 SHALL in ERR1 drive hready=0, hresp=01, no SRAM access; next state ERR2.
REQ-013 SHALL in ERR2 drive hready=1, hresp=01, hrdata=0.
REQ-014 SHALL from RESP/ERR2 go to IDLE when no transfer accepted that cycle, else per REQ-008 (back-to-back pipelining).
REQ-015 SHALL in IDLE drive hready=1, hresp=00, hrdata=0; hsel with htrans IDLE/BUSY gives zero-wait OKAY, no state change, no SRAM access.
REQ-016 SHALL ignore hsel/htrans in ACCESS and ERR1 (no address accepted while hready=0).
REQ-017 SHALL drive mem_cen=1, mem_gwen=1, mem_wen=16'hFFFF in every cycle without an SRAM access.
REQ-018 SHALL give data-phase length of WAIT_CYCLES+2 cycles for OKAY transfers, 2 cycles for ERROR.

Reset
REQ-019 SHALL on pad_cpu_rst_b=0 at a rising edge enter IDLE and clear wait counter and latched fields.
REQ-020 SHALL during and after reset drive hready=1, hresp=00, hrdata=0, mem_cen=1, mem_gwen=1, mem_wen=16'hFFFF, mem_addr=0, mem_wdata=0.
REQ-021 SHALL abort an in-flight ACCESS/ERR1 on reset with no SRAM access in the reset cycle.

Verification
REQ-022 SHALL cover: WAIT_CYCLES=0, write haddr=0x40, hsize=4, hwdata=128'hA5..A5 -> one ACCESS cycle hready=0, mem_addr=4, mem_wen=16'h0000, then RESP hready=1 OKAY.
REQ-023 SHALL cover: byte write haddr=0x43, hsize=0, then 16-byte read 0x40 -> mem_wen=16'hFFF7; read returns hrdata=mem_rdata in RESP.
REQ-024 SHALL cover: WAIT_CYCLES=3 read -> hready low exactly 4 cycles, mem_cen low only in 4th.
REQ-025 SHALL cover: haddr=0x42, hsize=2 (misaligned) and offset=2^(MEM_AW+4) -> ERR1 hready=0 hresp=01, ERR2 hready=1 hresp=01, mem_cen stays 1.
REQ-026 SHALL cover: back-to-back NONSEQ write then read accepted in RESP -> RESP to ACCESS directly, no IDLE cycle.
REQ-027 SHALL cover: reset asserted in ACCESS with WAIT_CYCLES=5 -> next cycle IDLE, hready=1, no SRAM access.
